gb_cart_bus_master: RTL and testbench

Initiator for the Game Boy cartridge bus: converts single-beat read/write requests from fabric logic into correctly phased A[15:0], RD_n, WR_n, CS_n and D[7:0] cycles, so the FPGA can act as the console side and read or write a real cartridge. The data bus leaves the block as per-bit drive data plus output enables and returns as sampled pad data; the top level connects these to an 8-bit `bidir_pad`, which registers both directions.

---
 rtl/gb_bus_pkg.sv | 20 ++
 rtl/gb_cart_bus_master_if.sv | 36 +++
 rtl/gb_phase_timer.sv | 28 ++
 rtl/gb_cart_bus_master.sv | 134 +++++++++++++
 tb/tb_gb_cart_bus_master.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the Game Boy cartridge bus initiator.
package gb_bus_pkg;

  localparam int GB_ADDR_W = 16;
  localparam int GB_DATA_W = 8;
  localparam logic [2:0] GB_XRAM_PREFIX = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    ACCESS,
    RECOVER
  } gb_bus_state_e;

  // A000-BFFF is the external-RAM window selected by CS_n.
  function automatic logic is_xram(input logic [GB_ADDR_W-1:0] a);
    return a[GB_ADDR_W-1 -: 3] == GB_XRAM_PREFIX;
  endfunction

endpackage

// File: rtl/gb_cart_bus_master_if.sv
// Fabric request/response handshake plus cartridge pin-side signals.
interface gb_cart_bus_master_if;
  import gb_bus_pkg::*;

  // Handshake: a request transfers on a clk edge where req_valid && req_ready;
  // req_* must stay stable while req_valid is high and not yet accepted.
  // rsp_valid is a single-cycle pulse with no back-pressure.
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [GB_ADDR_W-1:0] req_addr;
  logic [GB_DATA_W-1:0] req_wdata;
  logic                 rsp_valid;
  logic [GB_DATA_W-1:0] rsp_rdata;

  logic [GB_ADDR_W-1:0] cart_addr;
  logic                 cart_rd_n;
  logic                 cart_wr_n;
  logic                 cart_cs_n;
  logic [GB_DATA_W-1:0] data_out;
  logic [GB_DATA_W-1:0] data_oe;
  logic [GB_DATA_W-1:0] data_in;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, data_in,
    output req_ready, rsp_valid, rsp_rdata,
    output cart_addr, cart_rd_n, cart_wr_n, cart_cs_n, data_out, data_oe
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, data_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  cart_addr, cart_rd_n, cart_wr_n, cart_cs_n, data_out, data_oe
  );

endinterface

// File: rtl/gb_phase_timer.sv
// Loadable down-counter that times each bus phase; done when it reaches 0.
module gb_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         almost_done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done        = (cnt == '0);
    assign almost_done = (cnt == W'(1));

endmodule

// File: rtl/gb_cart_bus_master.sv
// Cartridge bus initiator: one request becomes an ADDR/ACCESS/RECOVER cycle
// of 1/2/1 phases, with every pin-side output driven straight from a flop.
module gb_cart_bus_master
    import gb_bus_pkg::*;
#(
    parameter int PHASE_CLKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    gb_cart_bus_master_if.master bus,
    output gb_bus_state_e       state_dbg
);

    localparam int CNT_W = $clog2(2 * PHASE_CLKS);
    localparam logic [CNT_W-1:0] LOAD_PHASE  = CNT_W'(PHASE_CLKS - 1);
    localparam logic [CNT_W-1:0] LOAD_ACCESS = CNT_W'(2 * PHASE_CLKS - 1);

    gb_bus_state_e        state;
    logic                 ready_q;
    logic                 rsp_valid_q;
    logic [GB_DATA_W-1:0] rdata_q;
    logic                 we_q;
    logic [GB_DATA_W-1:0] wdata_q;
    logic [GB_ADDR_W-1:0] addr_q;
    logic                 rd_n_q;
    logic                 wr_n_q;
    logic                 cs_n_q;
    logic [GB_DATA_W-1:0] dout_q;
    logic [GB_DATA_W-1:0] oe_q;

    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             tmr_almost;

    assign accept = bus.req_valid && ready_q;

    // Reload on acceptance and on every phase boundary except the last one.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = LOAD_PHASE;
        case (state)
            IDLE:    tmr_load = accept;
            ADDR:    begin tmr_load = tmr_done; tmr_val = LOAD_ACCESS; end
            ACCESS:  tmr_load = tmr_done;
            default: tmr_load = 1'b0;
        endcase
    end

    gb_phase_timer #(.W(CNT_W)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (tmr_load),
        .load_val    (tmr_val),
        .done        (tmr_done),
        .almost_done (tmr_almost)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            addr_q      <= '0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            cs_n_q      <= 1'b1;
            dout_q      <= '0;
            oe_q        <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= ADDR;
                        ready_q <= 1'b0;
                        we_q    <= bus.req_we;
                        wdata_q <= bus.req_wdata;
                        addr_q  <= bus.req_addr;
                        rd_n_q  <= bus.req_we;
                    end
                end
                ADDR: begin
                    if (tmr_done) begin
                        state  <= ACCESS;
                        cs_n_q <= ~is_xram(addr_q);
                        if (we_q) begin
                            wr_n_q <= 1'b0;
                            dout_q <= wdata_q;
                            oe_q   <= '1;
                        end
                    end
                end
                ACCESS: begin
                    if (tmr_done) begin
                        state  <= RECOVER;
                        rd_n_q <= 1'b1;
                        wr_n_q <= 1'b1;
                        cs_n_q <= 1'b1;
                        if (!we_q) rdata_q <= bus.data_in;
                        // A one-cycle RECOVER means its only cycle is the response cycle.
                        if (PHASE_CLKS == 1) rsp_valid_q <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (tmr_almost) rsp_valid_q <= 1'b1;
                    if (tmr_done) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        dout_q  <= '0;
                        oe_q    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.cart_addr = addr_q;
    assign bus.cart_rd_n = rd_n_q;
    assign bus.cart_wr_n = wr_n_q;
    assign bus.cart_cs_n = cs_n_q;
    assign bus.data_out  = dout_q;
    assign bus.data_oe   = oe_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// Directed bench for gb_cart_bus_master with N=4 and N=1 instances and a cartridge model.
module tb_gb_cart_bus_master;
  import gb_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v4 = 1'b0;
  logic        v1 = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [7:0]  din4 = 8'hFF;
  logic [7:0]  din1 = 8'hFF;
  logic        sel = 1'b0;

  gb_cart_bus_master_if bus4 ();
  gb_cart_bus_master_if bus1 ();
  gb_bus_state_e st4, st1;

  assign bus4.req_valid = v4;
  assign bus4.req_we    = req_we;
  assign bus4.req_addr  = req_addr;
  assign bus4.req_wdata = req_wdata;
  assign bus4.data_in   = din4;
  assign bus1.req_valid = v1;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.data_in   = din1;

  gb_cart_bus_master #(.PHASE_CLKS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .state_dbg(st4));
  gb_cart_bus_master #(.PHASE_CLKS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(st1));

  // Observed signals of the instance under test.
  logic          ready_m, rspv_m, rd_m, wr_m, cs_m;
  logic [7:0]    rdata_m, dout_m, oe_m;
  logic [15:0]   addr_m;
  gb_bus_state_e st_m;
  assign ready_m = sel ? bus1.req_ready : bus4.req_ready;
  assign rspv_m  = sel ? bus1.rsp_valid : bus4.rsp_valid;
  assign rdata_m = sel ? bus1.rsp_rdata : bus4.rsp_rdata;
  assign rd_m    = sel ? bus1.cart_rd_n : bus4.cart_rd_n;
  assign wr_m    = sel ? bus1.cart_wr_n : bus4.cart_wr_n;
  assign cs_m    = sel ? bus1.cart_cs_n : bus4.cart_cs_n;
  assign dout_m  = sel ? bus1.data_out  : bus4.data_out;
  assign oe_m    = sel ? bus1.data_oe   : bus4.data_oe;
  assign addr_m  = sel ? bus1.cart_addr : bus4.cart_addr;
  assign st_m    = sel ? st1 : st4;

  // Cartridge model: drives the pin while RD_n is low; pad input register adds 1 clk.
  logic [7:0]  mem [logic [15:0]];
  logic        wr4_prev = 1'b1;
  logic [15:0] last_waddr = '0;
  logic [7:0]  last_wdata = '0;
  int          wr_events = 0;

  function automatic logic [7:0] rom(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    din4 <= !bus4.cart_rd_n ? rom(bus4.cart_addr) : 8'hFF;
    din1 <= !bus1.cart_rd_n ? rom(bus1.cart_addr) : 8'hFF;
  end

  // Write latched on the rising edge of WR_n while data is still driven.
  always @(posedge clk) begin
    wr4_prev <= bus4.cart_wr_n;
    if (!wr4_prev && bus4.cart_wr_n && bus4.data_oe == 8'hFF) begin
      mem[bus4.cart_addr] = bus4.data_out;
      last_waddr <= bus4.cart_addr;
      last_wdata <= bus4.data_out;
      wr_events  <= wr_events + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic gb_bus_state_e exp_st(input int k, input int n);
    if (k <= n)     return ADDR;
    if (k <= 3 * n) return ACCESS;
    if (k <= 4 * n) return RECOVER;
    return IDLE;
  endfunction

  // Per-transaction statistics, cycle k counted from the acceptance edge.
  int rd_first, rd_last, rd_cnt;
  int wr_first, wr_last, wr_cnt;
  int cs_first, cs_last, cs_cnt;
  int oe_first, oe_last, oe_cnt;
  int rsp_cyc, rsp_cnt, ready_hi, st_bad, dout_bad;
  logic [7:0] rsp_data;
  logic       ready_end;

  task automatic run_txn(input logic s, input logic we, input logic [15:0] a,
                         input logic [7:0] wd, input int n);
    int t;
    sel = s; req_we = we; req_addr = a; req_wdata = wd;
    if (s) v1 = 1'b1; else v4 = 1'b1;
    t = 0;
    while (!ready_m && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready_m) begin
      chk("accept_timeout", 32'(ready_m), 32'd1);
      v1 = 1'b0; v4 = 1'b0;
      return;
    end
    @(posedge clk);
    #1 v1 = 1'b0; v4 = 1'b0;
    rd_first = -1; rd_last = -1; rd_cnt = 0;
    wr_first = -1; wr_last = -1; wr_cnt = 0;
    cs_first = -1; cs_last = -1; cs_cnt = 0;
    oe_first = -1; oe_last = -1; oe_cnt = 0;
    rsp_cyc = -1; rsp_cnt = 0; ready_hi = 0; st_bad = 0; dout_bad = 0;
    rsp_data = 8'h00; ready_end = 1'b0;
    for (int k = 1; k <= 4 * n + 1; k++) begin
      @(negedge clk);
      if (!rd_m) begin if (rd_first < 0) rd_first = k; rd_last = k; rd_cnt++; end
      if (!wr_m) begin if (wr_first < 0) wr_first = k; wr_last = k; wr_cnt++; end
      if (!cs_m) begin if (cs_first < 0) cs_first = k; cs_last = k; cs_cnt++; end
      if (oe_m != 8'h00) begin if (oe_first < 0) oe_first = k; oe_last = k; oe_cnt++; end
      if (oe_m != 8'h00 && (oe_m != 8'hFF || dout_m !== wd)) dout_bad++;
      if (addr_m !== a) dout_bad++;
      if (rspv_m) begin rsp_cyc = k; rsp_cnt++; rsp_data = rdata_m; end
      if (k <= 4 * n && ready_m) ready_hi++;
      if (k == 4 * n + 1) ready_end = ready_m;
      if (st_m !== exp_st(k, n)) st_bad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, rsp_n, wr_before, acc_t[3];
    mem[16'h0150] = 8'hC3;
    mem[16'hBFFF] = 8'h7E;
    mem[16'hC000] = 8'h11;

    // Reset state, checked while rst_n is still low.
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus4.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus4.rsp_valid), 32'd0);
    chk("rst_rdata", 32'(bus4.rsp_rdata), 32'd0);
    chk("rst_addr", 32'(bus4.cart_addr), 32'd0);
    chk("rst_strobes", {29'd0, bus4.cart_rd_n, bus4.cart_wr_n, bus4.cart_cs_n}, 32'd7);
    chk("rst_data", {16'd0, bus4.data_out, bus4.data_oe}, 32'd0);
    chk("rst_state", 32'(st4), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Read 0150, N=4.
    run_txn(1'b0, 1'b0, 16'h0150, 8'h00, 4);
    chk("rd_rdn_window", {rd_first[15:0], rd_last[15:0]}, {16'd1, 16'd12});
    chk("rd_rdn_count", rd_cnt, 12);
    chk("rd_rsp_cycle", rsp_cyc, 16);
    chk("rd_rsp_count", rsp_cnt, 1);
    chk("rd_rdata", 32'(rsp_data), 32'hC3);
    chk("rd_cs_oe_wr", cs_cnt + oe_cnt + wr_cnt, 0);
    chk("rd_state_trace", st_bad, 0);
    chk("rd_ready", {ready_hi[15:0], 15'd0, ready_end}, 32'd1);

    // Write 05 to 2000, N=4.
    run_txn(1'b0, 1'b1, 16'h2000, 8'h05, 4);
    chk("wr_oe_window", {oe_first[15:0], oe_last[15:0]}, {16'd5, 16'd16});
    chk("wr_oe_count", oe_cnt, 12);
    chk("wr_wrn_window", {wr_first[15:0], wr_last[15:0]}, {16'd5, 16'd12});
    chk("wr_wrn_count", wr_cnt, 8);
    chk("wr_rdn_count", rd_cnt, 0);
    chk("wr_cs_count", cs_cnt, 0);
    chk("wr_data_addr", dout_bad, 0);
    chk("wr_rsp_cycle", rsp_cyc, 16);
    chk("wr_rdata_held", 32'(rsp_data), 32'hC3);
    chk("wr_state_trace", st_bad, 0);
    @(negedge clk);
    chk("wr_model_latch", {last_waddr, 8'd0, last_wdata}, {16'h2000, 8'd0, 8'h05});

    // External-RAM select decode.
    run_txn(1'b0, 1'b1, 16'hA010, 8'h5A, 4);
    chk("xw_cs_window", {cs_first[15:0], cs_last[15:0]}, {16'd5, 16'd12});
    chk("xw_cs_count", cs_cnt, 8);
    run_txn(1'b0, 1'b0, 16'hBFFF, 8'h00, 4);
    chk("xr_cs_window", {cs_first[15:0], cs_last[15:0]}, {16'd5, 16'd12});
    chk("xr_cs_count", cs_cnt, 8);
    chk("xr_rdata", 32'(rsp_data), 32'h7E);
    run_txn(1'b0, 1'b0, 16'hC000, 8'h00, 4);
    chk("c000_cs_count", cs_cnt, 0);
    chk("c000_rdata", 32'(rsp_data), 32'h11);

    // Back-to-back: req_valid held high across three requests.
    sel = 1'b0; req_we = 1'b0; req_addr = 16'h4000;
    v4 = 1'b1; nacc = 0; rsp_n = 0;
    for (int c = 0; c < 80; c++) begin
      if (v4 && ready_m && nacc < 3) begin acc_t[nacc] = c; nacc++; end
      if (rspv_m) rsp_n++;
      @(posedge clk);
      #1;
      if (nacc == 3) v4 = 1'b0;
      @(negedge clk);
    end
    v4 = 1'b0;
    chk("b2b_accepts", nacc, 3);
    if (nacc == 3) begin
      chk("b2b_gap1", acc_t[1] - acc_t[0], 17);
      chk("b2b_gap2", acc_t[2] - acc_t[1], 17);
    end
    chk("b2b_rsp_count", rsp_n, 3);

    // Reset pulse during write ACCESS.
    sel = 1'b0; req_we = 1'b1; req_addr = 16'h3000; req_wdata = 8'hAA;
    v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_in_access", {31'd0, bus4.cart_wr_n}, 32'd0);
    wr_before = wr_events;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_strobes", {29'd0, bus4.cart_rd_n, bus4.cart_wr_n, bus4.cart_cs_n}, 32'd7);
    chk("abort_oe_dout", {16'd0, bus4.data_out, bus4.data_oe}, 32'd0);
    chk("abort_ready_state", {15'd0, bus4.req_ready, 14'd0, st4}, {15'd0, 1'b1, 14'd0, IDLE});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus4.rsp_valid) rsp_n++;
    end
    chk("abort_no_rsp", rsp_n, 0);
    chk("abort_no_latch", wr_events - wr_before, 0);
    run_txn(1'b0, 1'b0, 16'h0150, 8'h00, 4);
    chk("post_abort_rsp_cycle", rsp_cyc, 16);
    chk("post_abort_rdata", 32'(rsp_data), 32'hC3);

    // N=1 read: 1/2/1 phases.
    run_txn(1'b1, 1'b0, 16'h0150, 8'h00, 1);
    chk("n1_rdn_window", {rd_first[15:0], rd_last[15:0]}, {16'd1, 16'd3});
    chk("n1_rsp_cycle", rsp_cyc, 4);
    chk("n1_rsp_count", rsp_cnt, 1);
    chk("n1_rdata", 32'(rsp_data), 32'hC3);
    chk("n1_state_trace", st_bad, 0);
    chk("n1_ready_end", 32'(ready_end), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
